// File: rtl/bch_pattern_engine_if.sv
// Handshake bundle between bch_pattern_engine (master) and the bch decoder (slave).
interface bch_pattern_engine_if #(
  parameter int DATA_W = 64,
  parameter int ANS_W  = 10
);
  logic              dut_set;
  logic [1:0]        dut_code;
  logic              dut_mode;
  logic [DATA_W-1:0] dut_idata;
  logic              dut_ready;
  logic              dut_finish;
  logic [ANS_W-1:0]  dut_odata;

  modport master (
    output dut_set, dut_code, dut_mode, dut_idata,
    input  dut_ready, dut_finish, dut_odata
  );

  modport slave (
    input  dut_set, dut_code, dut_mode, dut_idata,
    output dut_ready, dut_finish, dut_odata
  );
endinterface

// File: rtl/bch_pattern_engine.sv
// Stimulus player and answer checker driving the bch decoder in the self-test wrapper.
// Define ERR_LOG_EN to add first-mismatch logging outputs.
//   state | meaning
//   IDLE  | after reset, waiting for start
//   SET   | one-cycle set pulse to bch, decode index advanced
//   RUN   | streaming data / checking answers until finish falls
//   GAP   | GAP_CYC quiet cycles before the next decode
//   DONE  | run complete, results held
//   TOUT  | run aborted, no progress within TOUT_CYC cycles
module bch_pattern_engine #(
  parameter int DATA_W   = 64,
  parameter int ANS_W    = 10,
  parameter int DATA_AW  = 13,
  parameter int ANS_AW   = 9,
  parameter int GAP_CYC  = 10,
  parameter int TOUT_CYC = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_we_i,
  input  logic                ld_sel_i,
  input  logic [DATA_AW-1:0]  ld_addr_i,
  input  logic [DATA_W-1:0]   ld_data_i,
  input  logic                start_i,
  input  logic [7:0]          ntest_i,
  input  logic [1:0]          cfg_code_i,
  input  logic                cfg_mode_i,
  bch_pattern_engine_if.master bch_if,
  output logic                busy_o,
  output logic                done_o,
  output logic                timeout_o,
  output logic [15:0]         ok_cnt_o,
  output logic [15:0]         err_cnt_o,
  output logic [31:0]         cyc_cnt_o
`ifdef ERR_LOG_EN
  ,
  output logic [ANS_AW-1:0]   first_err_idx_o,
  output logic [ANS_W-1:0]    first_err_exp_o,
  output logic [ANS_W-1:0]    first_err_got_o,
  output logic                first_err_vld_o
`endif
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int TMR_W = $clog2(TOUT_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_SET, S_RUN, S_GAP, S_DONE, S_TOUT} state_t;

  logic [DATA_W-1:0] data_mem [2**DATA_AW];
  logic [ANS_W-1:0]  ans_mem  [2**ANS_AW];

  state_t             state_q, state_d;
  logic [7:0]         test_idx_q;
  logic [DATA_AW-1:0] rd_ptr_q;
  logic [ANS_AW-1:0]  ans_ptr_q;
  logic [GAP_W-1:0]   gap_q;
  logic [TMR_W-1:0]   tmr_q;
  logic               finish_q;
  logic               set_q, busy_q, done_q, tout_q;
  logic [1:0]         code_q;
  logic               mode_q;
  logic [DATA_W-1:0]  idata_q;
  logic [15:0]        ok_q, err_q;
  logic [31:0]        cyc_q;
`ifdef ERR_LOG_EN
  logic [ANS_AW-1:0]  fe_idx_q;
  logic [ANS_W-1:0]   fe_exp_q, fe_got_q;
  logic               fe_vld_q;
`endif

  logic               busy_st, start_go, progress, ans_hit;
  logic [ANS_W-1:0]   exp_ans;

  always_comb begin
    busy_st  = (state_q == S_SET) || (state_q == S_RUN) || (state_q == S_GAP);
    start_go = start_i && !busy_st;
    progress = (state_q == S_SET) || bch_if.dut_ready || bch_if.dut_finish;
    exp_ans  = ans_mem[ans_ptr_q];
    ans_hit  = (bch_if.dut_odata == exp_ans);
    state_d  = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_TOUT:
        if (start_i) state_d = (ntest_i == 8'd0) ? S_DONE : S_SET;
      S_SET:
        state_d = S_RUN;
      S_RUN:
        if (finish_q && !bch_if.dut_finish) state_d = S_GAP;
      S_GAP:
        if (gap_q == '0) state_d = (test_idx_q < ntest_i) ? S_SET : S_DONE;
      default:
        state_d = S_IDLE;
    endcase
    if (busy_st && !progress && tmr_q == '0) state_d = S_TOUT;
  end

  // Load port is dropped while a run is in progress; memories are never reset.
  always_ff @(posedge clk) begin
    if (ld_we_i && !busy_st) begin
      if (ld_sel_i) ans_mem[ld_addr_i[ANS_AW-1:0]] <= ld_data_i[ANS_W-1:0];
      else          data_mem[ld_addr_i]            <= ld_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      test_idx_q <= '0;
      rd_ptr_q   <= '0;
      ans_ptr_q  <= '0;
      gap_q      <= '0;
      tmr_q      <= '0;
      finish_q   <= 1'b0;
      set_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tout_q     <= 1'b0;
      code_q     <= '0;
      mode_q     <= 1'b0;
      idata_q    <= '0;
      ok_q       <= '0;
      err_q      <= '0;
      cyc_q      <= '0;
`ifdef ERR_LOG_EN
      fe_idx_q   <= '0;
      fe_exp_q   <= '0;
      fe_got_q   <= '0;
      fe_vld_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      busy_q   <= (state_d == S_SET) || (state_d == S_RUN) || (state_d == S_GAP);
      done_q   <= (state_d == S_DONE);
      tout_q   <= (state_d == S_TOUT);
      set_q    <= (state_d == S_SET);
      finish_q <= bch_if.dut_finish;

      if (start_go) begin
        code_q     <= cfg_code_i;
        mode_q     <= cfg_mode_i;
        ok_q       <= '0;
        err_q      <= '0;
        cyc_q      <= '0;
        rd_ptr_q   <= '0;
        ans_ptr_q  <= '0;
        test_idx_q <= '0;
`ifdef ERR_LOG_EN
        fe_idx_q   <= '0;
        fe_exp_q   <= '0;
        fe_got_q   <= '0;
        fe_vld_q   <= 1'b0;
`endif
      end else if (busy_st) begin
        if (cyc_q != '1) cyc_q <= cyc_q + 32'd1;
        if (bch_if.dut_ready) begin
          idata_q  <= data_mem[rd_ptr_q];
          rd_ptr_q <= rd_ptr_q + DATA_AW'(1);
        end
        if (bch_if.dut_finish) begin
          if (ans_hit) begin
            if (ok_q != '1) ok_q <= ok_q + 16'd1;
          end else begin
            if (err_q != '1) err_q <= err_q + 16'd1;
          end
`ifdef ERR_LOG_EN
          if (!ans_hit && !fe_vld_q) begin
            fe_idx_q <= ans_ptr_q;
            fe_exp_q <= exp_ans;
            fe_got_q <= bch_if.dut_odata;
            fe_vld_q <= 1'b1;
          end
`endif
          ans_ptr_q <= ans_ptr_q + ANS_AW'(1);
        end
      end

      if (state_d == S_SET) test_idx_q <= start_go ? 8'd1 : test_idx_q + 8'd1;

      if (state_d == S_GAP && state_q != S_GAP) gap_q <= GAP_W'(GAP_CYC - 1);
      else if (state_q == S_GAP && gap_q != '0) gap_q <= gap_q - GAP_W'(1);

      // Down-counter reloads on any sign of life; reaching zero idle means timeout.
      if (state_d == S_SET || (busy_st && progress)) tmr_q <= TMR_W'(TOUT_CYC);
      else if (busy_st && tmr_q != '0)                tmr_q <= tmr_q - TMR_W'(1);
    end
  end

  assign bch_if.dut_set   = set_q;
  assign bch_if.dut_code  = code_q;
  assign bch_if.dut_mode  = mode_q;
  assign bch_if.dut_idata = idata_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign timeout_o        = tout_q;
  assign ok_cnt_o         = ok_q;
  assign err_cnt_o        = err_q;
  assign cyc_cnt_o        = cyc_q;
`ifdef ERR_LOG_EN
  assign first_err_idx_o  = fe_idx_q;
  assign first_err_exp_o  = fe_exp_q;
  assign first_err_got_o  = fe_got_q;
  assign first_err_vld_o  = fe_vld_q;
`endif

endmodule
